ft_run_monitor: RTL and testbench
=================================

// Module: ft_run_monitor
// PURPOSE
//  Downstream observer of the fault-tolerant SoC top. Consumes mem_flag/mem_result/instr_addr
//  and the injected error strobe, decides run completion (pass/fail/timeout), flags fetch stalls,
//  and measures error count and worst-case recovery latency. Synthesizable; used by benches and FPGA.
// PARAMETERS
//  TIMEOUT_CYCLES  2048  RUN cycles without mem_flag before TIMEOUT (>=2)
//  STALL_CYCLES    16    consecutive RUN cycles with unchanged instr_addr that raise stall_o (>=2)
//  CNT_W           16    width of cycle/recovery counters
// PORTS
//  clk_i              in   1      clock, all logic on rising edge
//  rst_i              in   1      reset, asynchronous, active-high
//  fetch_enable_i     in   1      SoC fetch enable; rising edge while IDLE starts a run
//  mem_flag_i         in   32     SoC completion flag; any nonzero = program done
//  mem_result_i       in   32     SoC result word, valid when mem_flag_i != 0
//  instr_addr_i       in   32     core-0 instruction address
//  error_i            in   1      fault-injection strobe driven into the SoC
//  expected_result_i  in   32     golden result, sampled with mem_flag
//  done_o             out  1      run ended (PASS, FAIL or TIMEOUT)
//  pass_o / fail_o    out  1      result matched / mismatched expected (mutually exclusive)
//  timeout_o          out  1      run ended by TIMEOUT_CYCLES expiry
//  stall_o            out  1      sticky: a stall was detected during the run
//  result_o           out  32     captured mem_result_i
//  cycles_o           out  CNT_W  RUN cycles until end (saturating)
//  error_count_o      out  8      rising edges of error_i during RUN (saturating at 255)
//  max_recover_o      out  CNT_W  worst error-rise-to-instr_addr-change latency (saturating)
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, fetch_enable/error/instr_addr history regs 0.
//  FSM states IDLE, RUN, PASS, FAIL, TIMEOUT (enum in package).
//   IDLE->RUN: fetch_enable_i=1 and previous-cycle fetch_enable=0. On entry clear cycles,
//     error_count, max_recover, stall, result, and stall counter.
//   RUN->PASS/FAIL: mem_flag_i!=0; capture mem_result_i into result_o same edge; PASS if
//     equal to expected_result_i else FAIL. mem_flag wins over timeout in the same cycle.
//   RUN->TIMEOUT: cycles counter reaches TIMEOUT_CYCLES-1 with mem_flag_i==0.
//   RUN->IDLE: fetch_enable_i=0 (SoC held/aborted); counters keep values, done_o stays 0.
//   PASS/FAIL/TIMEOUT are terminal until rst_i or a new fetch_enable rising edge (->RUN).
//  done/pass/fail/timeout: registered, asserted the cycle after the terminal transition edge,
//   held while in terminal state. Latency mem_flag_i -> done_o = 1 cycle.
//  cycles_o increments every RUN cycle, saturates at all-ones, frozen outside RUN.
//  Stall: counter increments when instr_addr_i equals last-cycle value, clears on change;
//   reaching STALL_CYCLES-1 sets stall_o (sticky for the run). Stall never ends the run.
//  Errors: error_i rising edge (registered edge detect) in RUN increments error_count_o.
//   Same edge arms recovery counter (cleared to 0); while armed it increments each cycle;
//   disarms on first instr_addr_i change, updating max_recover_o = max(max, count).
//   New error rise while armed restarts the count without updating max. Armed at run end:
//   no update. error_i held high counts once.
//  Comparisons unsigned; saturating counters never wrap.
//  rst_i mid-run: immediate async clear to reset values, FSM IDLE.
// STRUCTURE
//  ft_monitor_pkg: monitor_state_e enum, ERR_CNT_W=8 localparam, sat_inc function.
//  One sub-module: ft_recovery_timer (arm/disarm counter with running max), instantiated once.
//  Rest (FSM, stall detect, edge detects) in this file.
// TESTING
//  fetch rise, mem_flag=1 at cycle 40, result 55 == expected 55 -> pass_o=1 at 41, cycles_o=40.
//  Same run, expected 34 -> fail_o=1, pass_o=0, result_o=55.
//  TIMEOUT_CYCLES=64, mem_flag never set, addr advancing -> timeout_o=1 after 64 RUN cycles,
//   stall_o=0; mem_flag and expiry same cycle -> PASS/FAIL, not TIMEOUT.
//  instr_addr frozen 16 cycles in RUN -> stall_o=1 sticky; run still ends PASS on mem_flag.
//  Two error_i pulses (2 cycles high each), addr resumes after 3 then 7 cycles ->
//   error_count_o=2, max_recover_o=7; pulse at end of run with no resume -> max unchanged.
//  rst_i asserted mid-RUN with error_count=1 -> all outputs 0 asynchronously, FSM IDLE.

Source files
------------

// File: rtl/ft_monitor_pkg.sv
// ft_monitor_pkg: shared state encoding, widths and saturating increment for the run monitor
package ft_monitor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_PASS,
        ST_FAIL,
        ST_TIMEOUT
    } monitor_state_e;

    localparam int ERR_CNT_W = 8;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] top;
        top = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (v >= top) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/ft_recovery_timer.sv
// ft_recovery_timer: measures error-to-address-change latency and keeps the worst case seen
module ft_recovery_timer import ft_monitor_pkg::*; #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             arm,
    input  logic             change,
    output logic [CNT_W-1:0] max_latency
);

    logic             armed;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] lat;

    // lat counts the edges from the arming edge up to and including the current one
    assign lat = CNT_W'(sat_inc(32'(cnt), CNT_W));

    // Re-arming wins over a same-cycle address change; an unresolved arm never updates the max
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed       <= 1'b0;
            cnt         <= '0;
            max_latency <= '0;
        end else if (clr) begin
            armed       <= 1'b0;
            cnt         <= '0;
            max_latency <= '0;
        end else if (en) begin
            if (arm) begin
                armed <= 1'b1;
                cnt   <= '0;
            end else if (armed && change) begin
                armed       <= 1'b0;
                max_latency <= (lat > max_latency) ? lat : max_latency;
            end else if (armed) begin
                cnt <= lat;
            end
        end
    end

endmodule

// File: rtl/ft_run_monitor.sv
// ft_run_monitor: judges SoC run completion and tracks stalls, errors and recovery latency
module ft_run_monitor import ft_monitor_pkg::*; #(
    parameter int TIMEOUT_CYCLES = 2048,
    parameter int STALL_CYCLES   = 16,
    parameter int CNT_W          = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 fetch_enable_i,
    input  logic [31:0]          mem_flag_i,
    input  logic [31:0]          mem_result_i,
    input  logic [31:0]          instr_addr_i,
    input  logic                 error_i,
    input  logic [31:0]          expected_result_i,
    output logic                 done_o,
    output logic                 pass_o,
    output logic                 fail_o,
    output logic                 timeout_o,
    output logic                 stall_o,
    output logic [31:0]          result_o,
    output logic [CNT_W-1:0]     cycles_o,
    output logic [ERR_CNT_W-1:0] error_count_o,
    output logic [CNT_W-1:0]     max_recover_o
);

    monitor_state_e   state;
    logic             fetch_q;
    logic             error_q;
    logic [31:0]      addr_q;
    logic [CNT_W-1:0] stall_cnt;
    logic             in_run;
    logic             start;
    logic             err_rise;
    logic             addr_same;
    logic             flag_hit;
    logic             expire;
    logic             match;

    assign in_run    = state == ST_RUN;
    assign start     = fetch_enable_i && !fetch_q;
    assign err_rise  = error_i && !error_q;
    assign addr_same = instr_addr_i == addr_q;
    assign flag_hit  = mem_flag_i != 32'd0;
    assign expire    = cycles_o >= CNT_W'(TIMEOUT_CYCLES - 1);
    assign match     = mem_result_i == expected_result_i;

    // Last-cycle history of the inputs used for edge and change detection
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_q <= 1'b0;
            error_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            fetch_q <= fetch_enable_i;
            error_q <= error_i;
            addr_q  <= instr_addr_i;
        end
    end

    // Run FSM: counts RUN cycles, detects stalls and errors, captures the verdict
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= ST_IDLE;
            done_o        <= 1'b0;
            pass_o        <= 1'b0;
            fail_o        <= 1'b0;
            timeout_o     <= 1'b0;
            stall_o       <= 1'b0;
            result_o      <= '0;
            cycles_o      <= '0;
            error_count_o <= '0;
            stall_cnt     <= '0;
        end else if (in_run) begin
            cycles_o  <= CNT_W'(sat_inc(32'(cycles_o), CNT_W));
            stall_cnt <= addr_same ? CNT_W'(sat_inc(32'(stall_cnt), CNT_W)) : '0;
            stall_o   <= stall_o || (addr_same && stall_cnt >= CNT_W'(STALL_CYCLES - 2));
            if (err_rise)
                error_count_o <= ERR_CNT_W'(sat_inc(32'(error_count_o), ERR_CNT_W));
            if (flag_hit) begin
                state    <= match ? ST_PASS : ST_FAIL;
                result_o <= mem_result_i;
                done_o   <= 1'b1;
                pass_o   <= match;
                fail_o   <= !match;
            end else if (expire) begin
                state     <= ST_TIMEOUT;
                done_o    <= 1'b1;
                timeout_o <= 1'b1;
            end else if (!fetch_enable_i) begin
                state <= ST_IDLE;
            end
        end else if (start) begin
            state         <= ST_RUN;
            done_o        <= 1'b0;
            pass_o        <= 1'b0;
            fail_o        <= 1'b0;
            timeout_o     <= 1'b0;
            stall_o       <= 1'b0;
            result_o      <= '0;
            cycles_o      <= '0;
            error_count_o <= '0;
            stall_cnt     <= '0;
        end
    end

    ft_recovery_timer #(.CNT_W(CNT_W)) recovery (
        .clk         (clk_i),
        .rst         (rst_i),
        .clr         (start && !in_run),
        .en          (in_run),
        .arm         (err_rise),
        .change      (!addr_same),
        .max_latency (max_recover_o)
    );

endmodule

// File: tb/tb_ft_run_monitor.sv
// tb_ft_run_monitor: scenario tasks checked against a per-run trace model of the monitor rules
module tb_ft_run_monitor;

    localparam int T = 64;
    localparam int S = 16;
    localparam int W = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_enable = 1'b0;
    logic        error = 1'b0;
    logic [31:0] mem_flag = '0;
    logic [31:0] mem_result = '0;
    logic [31:0] instr_addr = '0;
    logic [31:0] expected_result = '0;
    logic        done, pass, fail, timeout, stall;
    logic [31:0] result;
    logic [W-1:0] cycles, max_recover;
    logic [7:0]  error_count;

    int n_checks = 0;
    int n_errors = 0;

    // Per-run input trace; index 0 is the cycle of the fetch rise, 1..T are RUN cycles
    logic [31:0] a_addr [0:T];
    logic [31:0] a_flag [0:T];
    logic [31:0] a_res  [0:T];
    logic        a_err  [0:T];

    always #5 clk = ~clk;

    ft_run_monitor #(.TIMEOUT_CYCLES(T), .STALL_CYCLES(S), .CNT_W(W)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .fetch_enable_i    (fetch_enable),
        .mem_flag_i        (mem_flag),
        .mem_result_i      (mem_result),
        .instr_addr_i      (instr_addr),
        .error_i           (error),
        .expected_result_i (expected_result),
        .done_o            (done),
        .pass_o            (pass),
        .fail_o            (fail),
        .timeout_o         (timeout),
        .stall_o           (stall),
        .result_o          (result),
        .cycles_o          (cycles),
        .error_count_o     (error_count),
        .max_recover_o     (max_recover)
    );

    task automatic fill_base(input logic [31:0] base);
        for (int k = 0; k <= T; k++) begin
            a_addr[k] = base + 32'(4 * k);
            a_flag[k] = '0;
            a_res[k]  = $urandom;
            a_err[k]  = 1'b0;
        end
    endtask

    task automatic freeze(input int from, input int to);
        for (int k = from; k <= to; k++) a_addr[k] = a_addr[from - 1];
    endtask

    task automatic start_run(input logic [31:0] exp_res);
        @(negedge clk);
        fetch_enable = 1'b0; error = 1'b0; mem_flag = '0;
        instr_addr = a_addr[0]; expected_result = exp_res;
        @(negedge clk);
        fetch_enable = 1'b1;
        @(negedge clk);
    endtask

    task automatic drive(input int k);
        mem_flag = a_flag[k]; mem_result = a_res[k];
        instr_addr = a_addr[k]; error = a_err[k];
        @(negedge clk);
    endtask

    task automatic do_run(input string name, input logic [31:0] exp_res);
        int kend, e_errs, e_max, c;
        logic hit, e_stall, ok;
        logic [3:0] e_flags;
        logic [31:0] e_res;
        kend = T; hit = 1'b0; e_errs = 0; e_max = 0; e_stall = 1'b0;
        for (int k = 1; k <= T; k++) if (a_flag[k] != 0) begin kend = k; hit = 1'b1; break; end
        for (int k = 1; k <= kend; k++) if (a_err[k] && !a_err[k-1]) e_errs++;
        for (int k = S - 1; k <= kend; k++) begin
            ok = 1'b1;
            for (int j = k - S + 2; j <= k; j++) if (a_addr[j] != a_addr[j-1]) ok = 1'b0;
            if (ok) e_stall = 1'b1;
        end
        for (int r = 1; r <= kend; r++) if (a_err[r] && !a_err[r-1]) begin
            c = 0;
            for (int j = r + 1; j <= kend; j++) begin
                if (a_err[j] && !a_err[j-1]) break;
                if (a_addr[j] != a_addr[j-1]) begin c = j; break; end
            end
            if (c != 0 && c - r > e_max) e_max = c - r;
        end
        e_res   = hit ? a_res[kend] : 32'd0;
        e_flags = {1'b1, hit && e_res == exp_res, hit && e_res != exp_res, !hit};
        start_run(exp_res);
        n_checks++;
        if (done !== 1'b0 || cycles !== '0) begin
            n_errors++;
            $display("FAIL %s start: done=%b cycles=%0d, want done=0 cycles=0", name, done, cycles);
        end
        for (int k = 1; k <= kend; k++) drive(k);
        n_checks++;
        if ({done, pass, fail, timeout} !== e_flags) begin
            n_errors++;
            $display("FAIL %s verdict: done/pass/fail/timeout=%b, want %b", name, {done, pass, fail, timeout}, e_flags);
        end
        n_checks++;
        if (stall !== e_stall) begin
            n_errors++;
            $display("FAIL %s stall: got %b want %b", name, stall, e_stall);
        end
        n_checks++;
        if (result !== e_res) begin
            n_errors++;
            $display("FAIL %s result: got %h want %h", name, result, e_res);
        end
        n_checks++;
        if (cycles !== W'(kend)) begin
            n_errors++;
            $display("FAIL %s cycles: got %0d want %0d", name, cycles, kend);
        end
        n_checks++;
        if (error_count !== 8'(e_errs)) begin
            n_errors++;
            $display("FAIL %s error_count: got %0d want %0d", name, error_count, e_errs);
        end
        n_checks++;
        if (max_recover !== W'(e_max)) begin
            n_errors++;
            $display("FAIL %s max_recover: got %0d want %0d", name, max_recover, e_max);
        end
        mem_flag = '0; error = 1'b0; instr_addr = instr_addr + 32'd4;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({done, pass, fail, timeout} !== e_flags || cycles !== W'(kend)) begin
            n_errors++;
            $display("FAIL %s hold: flags=%b cycles=%0d, want %b %0d", name, {done, pass, fail, timeout}, cycles, e_flags, kend);
        end
    endtask

    task automatic test_reset;
        #1;
        n_checks++;
        if ({done, pass, fail, timeout, stall, result, cycles, error_count, max_recover} !== '0) begin
            n_errors++;
            $display("FAIL reset: outputs not zero, done=%b result=%h cycles=%0d", done, result, cycles);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || cycles !== '0) begin
            n_errors++;
            $display("FAIL reset_idle: done=%b cycles=%0d, want 0 0", done, cycles);
        end
    endtask

    task automatic test_pass_fail;
        fill_base(32'h1000); a_flag[40] = 32'd1; a_res[40] = 32'd55;
        do_run("pass40", 32'd55);
        do_run("fail40", 32'd34);
    endtask

    task automatic test_timeout;
        fill_base(32'h4000);
        do_run("timeout", $urandom);
        fill_base(32'h5000); a_flag[T] = 32'h8000_0000; a_res[T] = 32'd7;
        do_run("flag_at_expiry_pass", 32'd7);
        do_run("flag_at_expiry_fail", 32'd8);
    endtask

    task automatic test_stall;
        fill_base(32'h6000); freeze(10, 24); a_flag[50] = 32'd1; a_res[50] = 32'd9;
        do_run("stall16", 32'd9);
        fill_base(32'h6000); freeze(10, 23); a_flag[50] = 32'd1; a_res[50] = 32'd9;
        do_run("stall15", 32'd9);
    endtask

    task automatic test_recovery;
        fill_base(32'h7000);
        a_err[5] = 1'b1; a_err[6] = 1'b1; freeze(5, 7);
        a_err[20] = 1'b1; a_err[21] = 1'b1; freeze(20, 26);
        a_err[36] = 1'b1; a_err[37] = 1'b1; freeze(36, 40);
        a_flag[40] = 32'd1; a_res[40] = 32'd3;
        do_run("recovery", 32'd3);
        n_checks++;
        if (max_recover !== W'(7)) begin
            n_errors++;
            $display("FAIL recovery_max: got %0d want 7", max_recover);
        end
    endtask

    task automatic test_abort;
        fill_base(32'h8000); a_err[3] = 1'b1;
        start_run(32'd0);
        for (int k = 1; k <= 10; k++) drive(k);
        fetch_enable = 1'b0; error = 1'b0;
        @(negedge clk);
        repeat (3) @(negedge clk);
        n_checks++;
        if ({done, pass, fail, timeout} !== 4'b0000 || error_count !== 8'd1) begin
            n_errors++;
            $display("FAIL abort: flags=%b error_count=%0d, want 0000 1", {done, pass, fail, timeout}, error_count);
        end
    endtask

    task automatic test_rst_mid_run;
        fill_base(32'h9000); a_err[3] = 1'b1; a_err[4] = 1'b1;
        start_run(32'd0);
        for (int k = 1; k <= 8; k++) drive(k);
        n_checks++;
        if (error_count !== 8'd1) begin
            n_errors++;
            $display("FAIL rst_pre: error_count got %0d want 1", error_count);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({done, pass, fail, timeout, stall, result, cycles, error_count, max_recover} !== '0) begin
            n_errors++;
            $display("FAIL rst_async: cycles=%0d error_count=%0d, want 0 0", cycles, error_count);
        end
        fetch_enable = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cycles !== '0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_idle: cycles=%0d done=%b, want 0 0", cycles, done);
        end
    endtask

    task automatic test_random;
        int s, fp;
        logic [31:0] exp_res;
        for (int i = 0; i < 12; i++) begin
            fill_base($urandom & 32'hFFFF_0000);
            for (int f = 0; f < 3; f++) begin
                s = $urandom_range(1, T - 20);
                freeze(s, s + $urandom_range(0, 18));
            end
            for (int k = 1; k <= T; k++) a_err[k] = ($urandom_range(0, 5) == 0);
            fp = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(2, T);
            if (fp != 0) a_flag[fp] = $urandom | 32'd1;
            exp_res = (fp != 0 && $urandom_range(0, 1) == 1) ? a_res[fp] : $urandom;
            do_run($sformatf("rand%0d", i), exp_res);
        end
    endtask

    initial begin
        test_reset;
        test_pass_fail;
        test_timeout;
        test_stall;
        test_recovery;
        test_abort;
        do_run("back_to_back", 32'd0);
        test_rst_mid_run;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
